// File: rtl/point_pkg.sv
// Shared stepper state encoding, default constants and sizing helpers for point_step_ctrl.
// Used by both the top level and the per-axis stepper.
package point_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } step_state_e;

  localparam int unsigned DefConfirmFields = 2;
  localparam int unsigned DefStepsPerField = 4;
  localparam int unsigned DefStepHigh      = 8;
  localparam int unsigned DefStepLow       = 56;
  localparam int unsigned DefDirSetup      = 4;
  localparam int unsigned DefLostFields    = 30;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold the value v itself (never less than one).
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// One stepper-motor axis: dir setup, then STEPS_PER_FIELD high/low step pulses per command.
// Commands arriving while a sequence is in flight are dropped, never queued.
module axis_stepper
  import point_pkg::*;
#(
  parameter int unsigned STEPS_PER_FIELD = DefStepsPerField,
  parameter int unsigned STEP_HIGH       = DefStepHigh,
  parameter int unsigned STEP_LOW        = DefStepLow,
  parameter int unsigned DIR_SETUP       = DefDirSetup
) (
  input  logic clk4mhz,
  input  logic reset,
  input  logic cmd,
  input  logic cmd_dir,
  output logic step,
  output logic dir,
  output logic busy
);

  localparam int unsigned PhaseMax = max3(DIR_SETUP, STEP_HIGH, STEP_LOW);
  localparam int unsigned PhaseW   = cnt_width(PhaseMax);
  localparam int unsigned StepW    = cnt_width(STEPS_PER_FIELD);

  localparam logic [PhaseW-1:0] SetupLast = PhaseW'(DIR_SETUP - 1);
  localparam logic [PhaseW-1:0] HighLast  = PhaseW'(STEP_HIGH - 1);
  localparam logic [PhaseW-1:0] LowLast   = PhaseW'(STEP_LOW - 1);
  localparam logic [StepW-1:0]  StepsLast = StepW'(STEPS_PER_FIELD - 1);

  step_state_e       state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [StepW-1:0]  steps_q, steps_d;
  logic              dir_q, dir_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (cmd) begin
          state_d = StSetup;
          phase_d = '0;
          steps_d = '0;
          dir_d   = cmd_dir;
        end
      end
      StSetup: begin
        if (phase_q == SetupLast) begin
          state_d = StHigh;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StHigh: begin
        if (phase_q == HighLast) begin
          state_d = StLow;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StLow: begin
        if (phase_q == LowLast) begin
          phase_d = '0;
          if (steps_q == StepsLast) begin
            state_d = StIdle;
          end else begin
            state_d = StHigh;
            steps_d = steps_q + StepW'(1);
          end
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk4mhz) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= '0;
      steps_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
    end
  end

  assign step = (state_q == StHigh);
  assign busy = (state_q != StIdle);
  assign dir  = dir_q;

endmodule

// File: rtl/point_step_ctrl.sv
// Field-rate pointing controller: votes on the detector's left/up flags and drives two steppers.
// Optional lost-target counter is built only when TRACK_LOST_EN is defined.
module point_step_ctrl
  import point_pkg::*;
#(
  parameter int unsigned CONFIRM_FIELDS  = DefConfirmFields,
  parameter int unsigned STEPS_PER_FIELD = DefStepsPerField,
  parameter int unsigned STEP_HIGH       = DefStepHigh,
  parameter int unsigned STEP_LOW        = DefStepLow,
  parameter int unsigned DIR_SETUP       = DefDirSetup,
  parameter int unsigned LOST_FIELDS     = DefLostFields
) (
  input  logic clk4mhz,
  input  logic reset,
  input  logic vsync,
  input  logic tgt_valid,
  input  logic az_lt,
  input  logic el_lt,
  output logic az_step,
  output logic az_dir,
  output logic el_step,
  output logic el_dir,
  output logic az_busy,
  output logic el_busy,
  output logic lost
);

  localparam int unsigned VoteW = cnt_width(CONFIRM_FIELDS);
  localparam logic [VoteW-1:0] VoteFull = VoteW'(CONFIRM_FIELDS);

  logic vs_s1_q, vs_s2_q, vs_s3_q;
  logic field_evt;

  // Index 0 is azimuth, index 1 is elevation.
  logic [1:0]            sample_dir;
  logic [1:0]            last_dir_q, last_dir_d;
  logic [1:0][VoteW-1:0] cnt_q, cnt_d;
  logic [1:0]            cmd_q, cmd_d;

  assign field_evt  = vs_s2_q & ~vs_s3_q;
  assign sample_dir = {el_lt, az_lt};

  always_comb begin
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    cmd_d      = '0;
    if (field_evt) begin
      for (int i = 0; i < 2; i++) begin
        if (!tgt_valid) begin
          cnt_d[i] = '0;
        end else if (sample_dir[i] == last_dir_q[i]) begin
          cnt_d[i] = (cnt_q[i] >= VoteFull) ? VoteFull : cnt_q[i] + VoteW'(1);
        end else begin
          cnt_d[i]      = VoteW'(1);
          last_dir_d[i] = sample_dir[i];
        end
        // Fires on every agreeing field once the vote is full, not only on the first.
        cmd_d[i] = (cnt_d[i] == VoteFull);
      end
    end
  end

  always_ff @(posedge clk4mhz) begin
    if (reset) begin
      vs_s1_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      vs_s3_q    <= 1'b0;
      last_dir_q <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
    end else begin
      vs_s1_q    <= vsync;
      vs_s2_q    <= vs_s1_q;
      vs_s3_q    <= vs_s2_q;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
    end
  end

`ifdef TRACK_LOST_EN
  localparam int unsigned LostW = cnt_width(LOST_FIELDS);
  localparam logic [LostW-1:0] LostFull = LostW'(LOST_FIELDS);

  logic [LostW-1:0] lost_cnt_q, lost_cnt_d;
  logic             lost_q, lost_d;

  always_comb begin
    lost_cnt_d = lost_cnt_q;
    lost_d     = lost_q;
    if (field_evt) begin
      if (tgt_valid) begin
        lost_cnt_d = '0;
        lost_d     = 1'b0;
      end else begin
        if (lost_cnt_q < LostFull) begin
          lost_cnt_d = lost_cnt_q + LostW'(1);
        end
        lost_d = (lost_cnt_d == LostFull);
      end
    end
  end

  always_ff @(posedge clk4mhz) begin
    if (reset) begin
      lost_cnt_q <= '0;
      lost_q     <= 1'b0;
    end else begin
      lost_cnt_q <= lost_cnt_d;
      lost_q     <= lost_d;
    end
  end

  assign lost = lost_q;
`else
  assign lost = 1'b0;
`endif

  axis_stepper #(
    .STEPS_PER_FIELD(STEPS_PER_FIELD),
    .STEP_HIGH      (STEP_HIGH),
    .STEP_LOW       (STEP_LOW),
    .DIR_SETUP      (DIR_SETUP)
  ) u_az (
    .clk4mhz(clk4mhz),
    .reset  (reset),
    .cmd    (cmd_q[0]),
    .cmd_dir(last_dir_q[0]),
    .step   (az_step),
    .dir    (az_dir),
    .busy   (az_busy)
  );

  axis_stepper #(
    .STEPS_PER_FIELD(STEPS_PER_FIELD),
    .STEP_HIGH      (STEP_HIGH),
    .STEP_LOW       (STEP_LOW),
    .DIR_SETUP      (DIR_SETUP)
  ) u_el (
    .clk4mhz(clk4mhz),
    .reset  (reset),
    .cmd    (cmd_q[1]),
    .cmd_dir(last_dir_q[1]),
    .step   (el_step),
    .dir    (el_dir),
    .busy   (el_busy)
  );

endmodule

// File: tb/tb_point_step_ctrl.sv
// Bench for point_step_ctrl: table of fields, random fields against a schedule model, corner cases.
// Lost-target expectations follow TRACK_LOST_EN as defined for this build.
module tb_point_step_ctrl;

  localparam int C   = 2;
  localparam int S   = 4;
  localparam int H   = 8;
  localparam int L   = 56;
  localparam int DS  = 4;
  localparam int LF  = 30;
  localparam int P   = H + L;
  localparam int DUR = DS + S * P;
`ifdef TRACK_LOST_EN
  localparam bit LostOn = 1'b1;
`else
  localparam bit LostOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vsync = 1'b0, tgt_valid = 1'b0, az_lt = 1'b0, el_lt = 1'b0;
  logic az_step, az_dir, el_step, el_dir, az_busy, el_busy, lost;
  logic vsync2 = 1'b0, tgt_valid2 = 1'b0, az_lt2 = 1'b0, el_lt2 = 1'b0;
  logic az_step2, az_dir2, el_step2, el_dir2, az_busy2, el_busy2, lost2;

  always #5 clk = ~clk;

  point_step_ctrl dut (
    .clk4mhz(clk), .reset(reset), .vsync(vsync), .tgt_valid(tgt_valid), .az_lt(az_lt),
    .el_lt(el_lt), .az_step(az_step), .az_dir(az_dir), .el_step(el_step), .el_dir(el_dir),
    .az_busy(az_busy), .el_busy(el_busy), .lost(lost)
  );

  point_step_ctrl #(.STEP_LOW(200)) dut2 (
    .clk4mhz(clk), .reset(reset), .vsync(vsync2), .tgt_valid(tgt_valid2), .az_lt(az_lt2),
    .el_lt(el_lt2), .az_step(az_step2), .az_dir(az_dir2), .el_step(el_step2), .el_dir(el_dir2),
    .az_busy(az_busy2), .el_busy(el_busy2), .lost(lost2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a list of accepted commands as absolute edge schedules.
  int cur_a[2], old_a[2];
  bit cur_dir[2], old_dir[2], has_cur[2], has_old[2];
  bit vlast[2];
  int vcnt[2];
  int lcnt, lost_edge;
  bit lost_prev, lost_new;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      has_cur[i] = 0; has_old[i] = 0; vlast[i] = 0; vcnt[i] = 0;
      cur_a[i] = 0; old_a[i] = 0; cur_dir[i] = 0; old_dir[i] = 0;
    end
    lcnt = 0; lost_prev = 0; lost_new = 0; lost_edge = 0;
  endfunction

  function automatic void model_field(input int e, input bit v, input bit az, input bit el);
    bit d[2];
    int acc;
    d[0] = az; d[1] = el;
    for (int i = 0; i < 2; i++) begin
      if (!v) vcnt[i] = 0;
      else if (d[i] == vlast[i]) vcnt[i] = (vcnt[i] + 1 > C) ? C : vcnt[i] + 1;
      else begin vcnt[i] = 1; vlast[i] = d[i]; end
      if (vcnt[i] == C) begin
        acc = e + 3;
        if (!has_cur[i] || acc > cur_a[i] + DUR) begin
          old_a[i] = cur_a[i]; old_dir[i] = cur_dir[i]; has_old[i] = has_cur[i];
          cur_a[i] = acc; cur_dir[i] = d[i]; has_cur[i] = 1;
        end
      end
    end
    lost_prev = lost_new;
    if (v) lcnt = 0;
    else if (lcnt < LF) lcnt++;
    lost_new = v ? 1'b0 : (lcnt == LF);
    lost_edge = e + 2;
  endfunction

  function automatic bit pick(input int i, input int t, output int a, output bit d);
    a = 0; d = 0;
    if (has_cur[i] && t >= cur_a[i]) begin a = cur_a[i]; d = cur_dir[i]; return 1; end
    if (has_old[i] && t >= old_a[i]) begin a = old_a[i]; d = old_dir[i]; return 1; end
    return 0;
  endfunction

  function automatic bit exp_step(input int i, input int t);
    int a, dd; bit d;
    if (!pick(i, t, a, d)) return 0;
    dd = t - (a + DS);
    return (dd >= 0) && (dd < S * P) && ((dd % P) < H);
  endfunction

  function automatic bit exp_busy(input int i, input int t);
    int a; bit d;
    if (!pick(i, t, a, d)) return 0;
    return t < a + DUR;
  endfunction

  function automatic bit exp_dir(input int i, input int t);
    int a; bit d;
    void'(pick(i, t, a, d));
    return d;
  endfunction

  function automatic bit exp_lost(input int t);
    if (!LostOn) return 0;
    return (t >= lost_edge) ? lost_new : lost_prev;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("az_step", az_step, exp_step(0, cyc));
      check("el_step", el_step, exp_step(1, cyc));
      check("az_busy", az_busy, exp_busy(0, cyc));
      check("el_busy", el_busy, exp_busy(1, cyc));
      check("az_dir", az_dir, exp_dir(0, cyc));
      check("el_dir", el_dir, exp_dir(1, cyc));
      check("lost", lost, exp_lost(cyc));
    end
  end

  // Pulse monitors.
  int az_pulses, el_pulses, az_first, el_first, az2_pulses, az2_accepts;
  logic az_p, el_p, az2_p, azb2_p;
  initial begin az_p = 0; el_p = 0; az2_p = 0; azb2_p = 0; end
  always @(negedge clk) begin
    if (az_step && !az_p) begin az_pulses++; if (az_first < 0) az_first = cyc; end
    if (el_step && !el_p) begin el_pulses++; if (el_first < 0) el_first = cyc; end
    if (az_step2 && !az2_p) az2_pulses++;
    if (az_busy2 && !azb2_p) az2_accepts++;
    az_p = az_step; el_p = el_step; az2_p = az_step2; azb2_p = az_busy2;
  end

  task automatic do_field(input bit v, input bit a, input bit e, input int gap, output int ev);
    @(negedge clk);
    vsync = 1; tgt_valid = v; az_lt = a; el_lt = e;
    ev = cyc + 1;
    model_field(ev, v, a, e);
    repeat (3) @(negedge clk);
    vsync = 0;
    tgt_valid = 1'($urandom); az_lt = 1'($urandom); el_lt = 1'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    bit v, az, el;
    int azp, elp;
    bit azd, eld;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int ev;
    int wait_cnt;
    bit pa, pe;
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 4, 4, 1, 0};
    tbl[2] = '{1, 1, 1, 4, 0, 1, 0};
    tbl[3] = '{1, 0, 1, 0, 4, 1, 1};
    tbl[4] = '{1, 0, 1, 4, 4, 0, 1};
    tbl[5] = '{0, 1, 1, 0, 0, 0, 1};
    tbl[6] = '{1, 0, 1, 0, 0, 0, 1};
    tbl[7] = '{1, 1, 1, 0, 4, 0, 1};
    tbl[8] = '{1, 0, 0, 0, 0, 0, 1};
    tbl[9] = '{1, 0, 0, 4, 4, 0, 0};

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_az_step", az_step, 0); check("rst_el_step", el_step, 0);
    check("rst_az_busy", az_busy, 0); check("rst_el_busy", el_busy, 0);
    check("rst_az_dir", az_dir, 0);   check("rst_el_dir", el_dir, 0);
    check("rst_lost", lost, 0);
    reset = 0;
    chk_en = 1;

    // Table-driven fields, each long enough for a full command to finish.
    for (int k = 0; k < 10; k++) begin
      az_pulses = 0; el_pulses = 0; az_first = -1; el_first = -1;
      do_field(tbl[k].v, tbl[k].az, tbl[k].el, 300, ev);
      check($sformatf("tbl%0d_az_pulses", k), az_pulses, tbl[k].azp);
      check($sformatf("tbl%0d_el_pulses", k), el_pulses, tbl[k].elp);
      check($sformatf("tbl%0d_az_dir", k), az_dir, tbl[k].azd);
      check($sformatf("tbl%0d_el_dir", k), el_dir, tbl[k].eld);
      check($sformatf("tbl%0d_lost", k), lost, 0);
      if (tbl[k].azp > 0) check($sformatf("tbl%0d_az_rise", k), az_first, ev + 3 + DS);
      if (tbl[k].elp > 0) check($sformatf("tbl%0d_el_rise", k), el_first, ev + 3 + DS);
    end

    // Random fields with random spacing; the model checks every cycle.
    pa = 0; pe = 0;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) pa = 1'($urandom);
      if ($urandom_range(0, 3) == 0) pe = 1'($urandom);
      do_field($urandom_range(0, 9) != 0, pa, pe, $urandom_range(5, 400), ev);
    end
    repeat (300) @(negedge clk);

    // Lost: 30 consecutive invalid fields, then one valid.
    do_field(1, 0, 0, 10, ev);
    for (int k = 0; k < LF - 1; k++) do_field(0, 0, 0, 10, ev);
    check("lost_before_sat", lost, 0);
    do_field(0, 0, 0, 0, ev);
    check("lost_at_sat", lost, LostOn);
    do_field(1, 0, 0, 10, ev);
    check("lost_cleared", lost, 0);
    repeat (300) @(negedge clk);

    // Reset during an elevation HIGH phase.
    do_field(1, 0, 1, 10, ev);
    do_field(1, 0, 1, 0, ev);
    wait_cnt = 0;
    while (!el_step && wait_cnt < 200) begin @(negedge clk); wait_cnt++; end
    check("el_high_reached", el_step, 1);
    chk_en = 0;
    reset = 1;
    @(posedge clk); #1;
    check("rstmid_el_step", el_step, 0);
    check("rstmid_el_busy", el_busy, 0);
    check("rstmid_az_busy", az_busy, 0);
    check("rstmid_el_dir", el_dir, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    chk_en = 1;
    el_pulses = 0;
    repeat (200) @(negedge clk);
    do_field(1, 0, 1, 300, ev);
    check("rstmid_no_pulses", el_pulses, 0);
    chk_en = 0;

    // Long STEP_LOW instance: confirmed cmd every 300 cycles, busy ones dropped.
    az2_pulses = 0; az2_accepts = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vsync2 = 1; tgt_valid2 = 1; az_lt2 = 1; el_lt2 = 0;
      repeat (3) @(negedge clk);
      vsync2 = 0;
      if (k == 2) check("drop_busy_at_f3", az_busy2, 1);
      repeat (296) @(negedge clk);
    end
    repeat (900) @(negedge clk);
    check("drop_accepts", az2_accepts, 3);
    check("drop_pulses", az2_pulses, 3 * S);
    check("drop_dir", az_dir2, 1);
    check("drop_idle", az_busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
